// File: rtl/agree_br_predictor.sv
// Agree-style branch predictor for the 5-stage RV32I pipeline.
// A direct-mapped BTB holds the target and a static bias bit for each branch.
// A gshare-indexed PHT of 2-bit counters records whether the branch agrees
// with that bias. The predicted direction is bias XNOR counter[1].
// Optional statistics counters are built only when AGREE_PRED_STATS_EN is defined.
module agree_br_predictor #(
  parameter int BTB_IDX_W = 5,
  parameter int PHT_IDX_W = 6,
  parameter int GHR_W     = 6
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc_f,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_upd_valid,
  input  logic [31:0] i_pc_e,
  input  logic        i_taken_e,
  input  logic [31:0] i_target_e,
  input  logic        i_pred_taken_e,
  input  logic [31:0] i_pred_target_e,
  output logic        o_mispredict,
  output logic [31:0] o_redirect_pc
`ifdef AGREE_PRED_STATS_EN
  ,
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_mispred_cnt
`endif
);

  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int PHT_N = 1 << PHT_IDX_W;
  localparam int TAG_W = 32 - BTB_IDX_W - 2;

  logic                 btb_valid_q [BTB_N];
  logic [TAG_W-1:0]     btb_tag_q   [BTB_N];
  logic [31:0]          btb_tgt_q   [BTB_N];
  logic                 btb_bias_q  [BTB_N];
  logic [1:0]           pht_q       [PHT_N];
  logic [GHR_W-1:0]     ghr_q, ghr_d;

  logic [PHT_IDX_W-1:0] ghr_ext;
  logic [BTB_IDX_W-1:0] btb_idx_f, btb_idx_e;
  logic [TAG_W-1:0]     tag_f, tag_e;
  logic [PHT_IDX_W-1:0] pht_idx_f, pht_idx_e;
  logic                 hit_f, hit_e;
  logic                 btb_alloc, btb_tgt_we, pht_we;
  logic [1:0]           pht_cur, pht_d;

  // History is zero-extended into the PHT index width before hashing.
  assign ghr_ext   = PHT_IDX_W'(ghr_q);

  assign btb_idx_f = i_pc_f[BTB_IDX_W+1:2];
  assign tag_f     = i_pc_f[31:BTB_IDX_W+2];
  assign pht_idx_f = i_pc_f[PHT_IDX_W+1:2] ^ ghr_ext;

  assign btb_idx_e = i_pc_e[BTB_IDX_W+1:2];
  assign tag_e     = i_pc_e[31:BTB_IDX_W+2];
  assign pht_idx_e = i_pc_e[PHT_IDX_W+1:2] ^ ghr_ext;

  assign hit_f = btb_valid_q[btb_idx_f] && (btb_tag_q[btb_idx_f] == tag_f);
  assign hit_e = btb_valid_q[btb_idx_e] && (btb_tag_q[btb_idx_e] == tag_e);

  // Fetch-side prediction reads the arrays directly, so a same-cycle update is not visible yet.
  always_comb begin
    o_pred_taken  = hit_f & (btb_bias_q[btb_idx_f] ~^ pht_q[pht_idx_f][1]);
    o_pred_target = o_pred_taken ? btb_tgt_q[btb_idx_f] : (i_pc_f + 32'd4);
  end

  // Compare the EX resolution against the prediction that travelled with the instruction.
  always_comb begin
    o_mispredict  = i_upd_valid &
                    ((i_taken_e != i_pred_taken_e) |
                     (i_taken_e & (i_target_e != i_pred_target_e)));
    o_redirect_pc = i_taken_e ? i_target_e : (i_pc_e + 32'd4);
  end

  // Training decisions: BTB write/alloc enables and the saturating agree-counter step.
  always_comb begin
    btb_alloc  = i_upd_valid & ~hit_e & i_taken_e;
    btb_tgt_we = i_upd_valid & i_taken_e;
    pht_we     = i_upd_valid & hit_e;
    pht_cur    = pht_q[pht_idx_e];
    pht_d      = pht_cur;
    if (i_taken_e == btb_bias_q[btb_idx_e]) begin
      if (pht_cur != 2'b11) pht_d = pht_cur + 2'd1;
    end else begin
      if (pht_cur != 2'b00) pht_d = pht_cur - 2'd1;
    end
    ghr_d = ghr_q;
    if (i_upd_valid) ghr_d = {ghr_q[GHR_W-2:0], i_taken_e};
  end

  // BTB storage: the target is refreshed on any taken resolution, and a missing taken branch allocates an entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BTB_N; i++) begin
        btb_valid_q[i] <= 1'b0;
        btb_tag_q[i]   <= '0;
        btb_tgt_q[i]   <= '0;
        btb_bias_q[i]  <= 1'b0;
      end
    end else begin
      if (btb_tgt_we) btb_tgt_q[btb_idx_e] <= i_target_e;
      if (btb_alloc) begin
        btb_valid_q[btb_idx_e] <= 1'b1;
        btb_tag_q[btb_idx_e]   <= tag_e;
        btb_bias_q[btb_idx_e]  <= 1'b1;
      end
    end
  end

  // PHT agree counters reset to weak-agree, and only BTB hits train them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b10;
    end else if (pht_we) begin
      pht_q[pht_idx_e] <= pht_d;
    end
  end

  // Non-speculative global history that shifts in each resolved outcome.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ghr_q <= '0;
    else          ghr_q <= ghr_d;
  end

`ifdef AGREE_PRED_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d, mispred_cnt_q, mispred_cnt_d;

  // Saturating event counts.
  always_comb begin
    br_cnt_d      = br_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (i_upd_valid  && (br_cnt_q      != 32'hFFFF_FFFF)) br_cnt_d      = br_cnt_q + 32'd1;
    if (o_mispredict && (mispred_cnt_q != 32'hFFFF_FFFF)) mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign o_br_cnt      = br_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_agree_br_predictor.sv
// Directed scoreboard bench for agree_br_predictor.
// Each step drives one cycle of fetch and EX inputs and pushes the hand-derived expected outputs.
// Those expectations are then popped and compared in the middle of the cycle.
module tb_agree_br_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_f;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] pc_e;
  logic        taken_e;
  logic [31:0] target_e;
  logic        pred_taken_e;
  logic [31:0] pred_target_e;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef AGREE_PRED_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;
`endif

  agree_br_predictor dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_pc_f         (pc_f),
    .o_pred_taken   (pred_taken),
    .o_pred_target  (pred_target),
    .i_upd_valid    (upd_valid),
    .i_pc_e         (pc_e),
    .i_taken_e      (taken_e),
    .i_target_e     (target_e),
    .i_pred_taken_e (pred_taken_e),
    .i_pred_target_e(pred_target_e),
    .o_mispredict   (mispredict),
    .o_redirect_pc  (redirect_pc)
`ifdef AGREE_PRED_STATS_EN
    ,
    .o_br_cnt       (br_cnt),
    .o_mispred_cnt  (mispred_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_no  = 0;
  int   br_exp   = 0;
  int   mis_exp  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return {31'd0, pred_taken};
      1:       return pred_target;
      2:       return {31'd0, mispredict};
      3:       return redirect_pc;
`ifdef AGREE_PRED_STATS_EN
      4:       return br_cnt;
      5:       return mispred_cnt;
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = $sformatf("s%0d_%s", step_no, tag);
    e.sel = sel;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, observe(e.sel), e.val);
    end
  endtask

  // One cycle: drive at negedge, optionally pull reset, then check 2ns later (well before the posedge).
  task automatic step(input logic [31:0] f_pc, input logic uv, input logic [31:0] e_pc,
                      input logic tk, input logic [31:0] tgt, input logic ptk,
                      input logic [31:0] ptgt, input logic x_pt, input logic [31:0] x_ptgt,
                      input logic x_mis, input logic [31:0] x_redir, input logic do_rst);
    @(negedge clk);
    step_no++;
    pc_f          = f_pc;
    upd_valid     = uv;
    pc_e          = e_pc;
    taken_e       = tk;
    target_e      = tgt;
    pred_taken_e  = ptk;
    pred_target_e = ptgt;
    if (do_rst) begin
      rst_n   = 1'b0;
      br_exp  = 0;
      mis_exp = 0;
    end
    push("pred_taken", 0, {31'd0, x_pt});
    push("pred_target", 1, x_ptgt);
    push("mispredict", 2, {31'd0, x_mis});
    push("redirect", 3, x_redir);
`ifdef AGREE_PRED_STATS_EN
    push("br_cnt", 4, br_exp);
    push("mispred_cnt", 5, mis_exp);
`endif
    #2;
    drain();
    if (uv) br_exp++;
    if (x_mis) mis_exp++;
  endtask

  initial begin
    rst_n = 1'b0;
    pc_f = 32'h100; upd_valid = 0; pc_e = 0; taken_e = 0;
    target_e = 0; pred_taken_e = 0; pred_target_e = 0;

    // Reset state: no BTB hit, fall-through target.
    step(32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0,  0, 32'h104, 0, 32'h4, 0);
    rst_n = 1'b1;

    // First taken resolution: mispredict, allocate; same-cycle fetch still sees the empty BTB.
    step(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104,  0, 32'h104, 1, 32'h80, 0);
    // GHR=1 -> PHT idx 1 (weak agree) with bias 1 -> taken.
    step(32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0,  1, 32'h80, 0, 32'h4, 0);
    // Not-taken resolution: direction mispredict; PHT[1] becomes 01 and GHR becomes 2.
    step(32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80,  1, 32'h80, 1, 32'h104, 0);
    // GHR=2 -> index 2 is still weak agree -> still taken.
    step(32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0,  1, 32'h80, 0, 32'h4, 0);
    // Five not-taken misses at 0x2000 (same BTB set, different tag) flush GHR to 0.
    for (int i = 0; i < 5; i++)
      step(32'h2000, 1, 32'h2000, 0, 32'h0, 0, 32'h2004,  0, 32'h2004, 0, 32'h2004, 0);
    // GHR=0: train PHT[0] 10->01 with the not-taken outcome; the same-cycle prediction is still taken.
    step(32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80,  1, 32'h80, 1, 32'h104, 0);
    // GHR is still 0, so the same index now predicts not taken.
    step(32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0,  0, 32'h104, 0, 32'h4, 0);
    // Drive PHT[0] to 00, then try to push it past the floor.
    step(32'h100, 1, 32'h100, 0, 32'h80, 0, 32'h104,  0, 32'h104, 0, 32'h104, 0);
    step(32'h100, 1, 32'h100, 0, 32'h80, 0, 32'h104,  0, 32'h104, 0, 32'h104, 0);
    // A wrap to 11 would predict taken here.
    step(32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0,  0, 32'h104, 0, 32'h4, 0);
    // Wrong target only: mispredict and redirect to 0x90; BTB target is rewritten, PHT[0] becomes 01, GHR=1.
    step(32'h100, 1, 32'h100, 1, 32'h90, 1, 32'h80,  0, 32'h104, 1, 32'h90, 0);
    // GHR=1 -> PHT[1]=01 -> not taken.
    step(32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0,  0, 32'h104, 0, 32'h4, 0);
    // Correct prediction; the same-cycle fetch still sees PHT[1]=01. After the edge, PHT[1]=10 and GHR=3.
    step(32'h100, 1, 32'h100, 1, 32'h90, 1, 32'h90,  0, 32'h104, 0, 32'h90, 0);
    // GHR=3 -> PHT[3]=10 -> taken, using the updated target.
    step(32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0,  1, 32'h90, 0, 32'h4, 0);
    // upd_valid low masks a mismatch; PC wraps on both adders.
    step(32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1, 32'h1234, 0, 32'h0,  0, 32'h0, 0, 32'h1234, 0);
    step(32'h100, 0, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0,  1, 32'h90, 0, 32'h0, 0);
    // Reset mid-stream: outputs drop to reset values at once.
    step(32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0,  0, 32'h104, 0, 32'h4, 1);
    rst_n = 1'b1;
    // All training is gone.
    step(32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0,  0, 32'h104, 0, 32'h4, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
